button_conditioner: RTL and testbench

- Input-side counterpart to the 7-segment output path: turns raw, bouncing, asynchronous push-buttons into clean command pulses for the stopwatch FSM.
- Synchronizes and debounces two buttons, classifies start button presses as short or long (long = clear), and stretches each command so the 1 kHz FSM clock domain reliably samples it.
- Sits between the board button pins and the start_stop/clear inputs of the stopwatch top; runs on the 100 MHz board clock.

---
 rtl/button_conditioner.sv | 245 ++++++++++++++++++++++++
 tb/tb_button_conditioner.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: turns two raw, bouncing, asynchronous push-buttons into
// clean commands for the stopwatch FSM.
//   clk           100 MHz board clock
//   reset         asynchronous, active-low reset
//   btn_start_raw raw start/stop button (active-high, asynchronous)
//   btn_clear_raw raw clear button (active-high, asynchronous)
//   start_stop    start/stop command stretched to PULSE_CYCLES
//   clear         clear command stretched to PULSE_CYCLES
//   start_evt     single-cycle start/stop event
//   clear_evt     single-cycle clear event (clear button or long start press)
//   start_level   debounced start button level
//   clear_level   debounced clear button level

// Per-button synchronizer and debounce FSM.
//   clk, reset   as the top level
//   raw          asynchronous button input
//   level        debounced level (registered)
//   level_nxt_c  level value to be registered on the next edge (combinational)
module button_conditioner_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic level_nxt_c
);

  localparam int unsigned CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam bit          ONE_SHOT = (DEBOUNCE_CYCLES == 1);

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    ARM_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    ARM_RELEASE = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          sync_q1, sync_q2;

  // Two-flop synchronizer; only sync_q2 feeds the debounce logic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  // State, stability counter and level registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RELEASED;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      level <= level_nxt_c;
    end
  end

  // The entry transition counts as the first stable sample, so the level
  // flips on the DEBOUNCE_CYCLES-th consecutive sample.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    level_nxt_c = level;
    case (state)
      RELEASED: begin
        if (sync_q2) begin
          if (ONE_SHOT) begin
            state_nxt   = PRESSED;
            level_nxt_c = 1'b1;
            cnt_nxt     = '0;
          end else begin
            state_nxt = ARM_PRESS;
            cnt_nxt   = CW'(1);
          end
        end
      end
      ARM_PRESS: begin
        if (!sync_q2) begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = PRESSED;
          level_nxt_c = 1'b1;
          cnt_nxt     = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      PRESSED: begin
        if (!sync_q2) begin
          if (ONE_SHOT) begin
            state_nxt   = RELEASED;
            level_nxt_c = 1'b0;
            cnt_nxt     = '0;
          end else begin
            state_nxt = ARM_RELEASE;
            cnt_nxt   = CW'(1);
          end
        end
      end
      ARM_RELEASE: begin
        if (sync_q2) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = RELEASED;
          level_nxt_c = 1'b0;
          cnt_nxt     = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt   = RELEASED;
        cnt_nxt     = '0;
        level_nxt_c = 1'b0;
      end
    endcase
  end

endmodule

module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
  parameter int unsigned LONG_PRESS_CYCLES = 200000000,
  parameter int unsigned PULSE_CYCLES      = 150000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_start_raw,
  input  logic btn_clear_raw,
  output logic start_stop,
  output logic clear,
  output logic start_evt,
  output logic clear_evt,
  output logic start_level,
  output logic clear_level
);

  localparam int unsigned HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam int unsigned PW = $clog2(PULSE_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
  localparam logic [PW-1:0] PULSE_LD  = PW'(PULSE_CYCLES);

  logic          start_level_nxt_c, clear_level_nxt_c;
  logic          start_fall_c, clear_rise_c, long_hit_c;
  logic          start_evt_nxt_c, clear_evt_nxt_c;
  logic [HW-1:0] hold_cnt;
  logic          long_flag;
  logic [PW-1:0] start_cnt, clear_cnt;

  button_conditioner_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
    .clk         (clk),
    .reset       (reset),
    .raw         (btn_start_raw),
    .level       (start_level),
    .level_nxt_c (start_level_nxt_c)
  );

  button_conditioner_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
    .clk         (clk),
    .reset       (reset),
    .raw         (btn_clear_raw),
    .level       (clear_level),
    .level_nxt_c (clear_level_nxt_c)
  );

  // Events are registered alongside the level change that causes them;
  // a clear from either source masks a coincident start event.
  always_comb begin
    start_fall_c    = start_level & ~start_level_nxt_c;
    clear_rise_c    = clear_level_nxt_c & ~clear_level;
    long_hit_c      = start_level & ~long_flag & (hold_cnt == HOLD_LAST);
    clear_evt_nxt_c = clear_rise_c | long_hit_c;
    start_evt_nxt_c = start_fall_c & ~long_flag & ~clear_evt_nxt_c;
  end

  // Hold timer for the long-press (clear) path.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_cnt  <= '0;
      long_flag <= 1'b0;
    end else if (!start_level || start_fall_c) begin
      hold_cnt  <= '0;
      long_flag <= 1'b0;
    end else begin
      if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + HW'(1);
      if (long_hit_c) long_flag <= 1'b1;
    end
  end

  // Single-cycle event registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_evt <= 1'b0;
      clear_evt <= 1'b0;
    end else begin
      start_evt <= start_evt_nxt_c;
      clear_evt <= clear_evt_nxt_c;
    end
  end

  // Clear stretcher: reload on every event, high while the counter runs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clear_cnt <= '0;
      clear     <= 1'b0;
    end else if (clear_evt) begin
      clear_cnt <= PULSE_LD;
      clear     <= 1'b1;
    end else if (clear_cnt != '0) begin
      clear_cnt <= clear_cnt - PW'(1);
      clear     <= (clear_cnt != PW'(1));
    end
  end

  // Start stretcher; any clear event cancels it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_cnt  <= '0;
      start_stop <= 1'b0;
    end else if (clear_evt) begin
      start_cnt  <= '0;
      start_stop <= 1'b0;
    end else if (start_evt) begin
      start_cnt  <= PULSE_LD;
      start_stop <= 1'b1;
    end else if (start_cnt != '0) begin
      start_cnt  <= start_cnt - PW'(1);
      start_stop <= (start_cnt != PW'(1));
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

  localparam int D = 4;
  localparam int L = 20;
  localparam int P = 3;

  logic clk = 1'b0;
  logic reset;
  logic btn_start_raw, btn_clear_raw;
  logic start_stop, clear, start_evt, clear_evt, start_level, clear_level;
  logic [5:0] dut_out;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES   (D),
    .LONG_PRESS_CYCLES (L),
    .PULSE_CYCLES      (P)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_start_raw (btn_start_raw),
    .btn_clear_raw (btn_clear_raw),
    .start_stop    (start_stop),
    .clear         (clear),
    .start_evt     (start_evt),
    .clear_evt     (clear_evt),
    .start_level   (start_level),
    .clear_level   (clear_level)
  );

  // {start_level, start_evt, start_stop, clear_level, clear_evt, clear}
  assign dut_out = {start_level, start_evt, start_stop, clear_level, clear_evt, clear};

  int n_checks = 0;
  int n_err    = 0;

  task automatic check6(input string nm, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Levels flip after D consecutive synchronized samples that disagree with
  // the current level; synchronized sample = raw value seen two edges earlier.
  bit   hs[$];
  bit   hc[$];
  bit   m_lvl_s, m_lvl_c, m_long, m_ps, m_pc;
  int   m_run_s, m_run_c, m_held, m_n, m_exp_s, m_exp_c;
  logic [5:0] m_out;

  task automatic model_reset();
    hs.delete(); hc.delete();
    m_lvl_s = 0; m_lvl_c = 0; m_long = 0; m_ps = 0; m_pc = 0;
    m_run_s = 0; m_run_c = 0; m_held = 0;
    m_exp_s = -1; m_exp_c = -1;
    m_out = '0;
  endtask

  task automatic model_step(input bit s, input bit c);
    bit ss, sc, ps, pc, cr, sf, le, lb, cevt, sevt;
    m_n++;
    // Commands registered last edge become pulses lasting P cycles from now.
    if (m_pc) begin
      m_exp_c = m_n + P - 1;
      if (m_exp_s > m_n - 1) m_exp_s = m_n - 1;
    end else if (m_ps) begin
      m_exp_s = m_n + P - 1;
    end
    hs.push_back(s); hc.push_back(c);
    ss = 0; sc = 0;
    if (hs.size() > 2) ss = hs.pop_front();
    if (hc.size() > 2) sc = hc.pop_front();
    ps = m_lvl_s; pc = m_lvl_c;
    if (ss != m_lvl_s) begin
      m_run_s++;
      if (m_run_s == D) begin m_lvl_s = !m_lvl_s; m_run_s = 0; end
    end else m_run_s = 0;
    if (sc != m_lvl_c) begin
      m_run_c++;
      if (m_run_c == D) begin m_lvl_c = !m_lvl_c; m_run_c = 0; end
    end else m_run_c = 0;
    cr = m_lvl_c && !pc;
    sf = ps && !m_lvl_s;
    lb = m_long;
    le = 0;
    if (ps) begin
      if (m_held < L) m_held++;
      if (m_held == L && !m_long) begin le = 1; m_long = 1; end
    end
    cevt = cr || le;
    sevt = sf && !lb && !cevt;
    if (sf || !m_lvl_s) begin m_held = 0; m_long = 0; end
    m_out = {m_lvl_s, sevt, (m_n <= m_exp_s), m_lvl_c, cevt, (m_n <= m_exp_c)};
    m_ps = sevt; m_pc = cevt;
  endtask

  // ---------------- scenario observations ----------------
  int cyc, o_first_sevt, o_first_cevt, o_cnt_sevt, o_cnt_cevt;
  int o_cnt_ss, o_cnt_clr, o_first_clr, o_last_clr, o_lvl_s_rise, o_lvl_c_rise;
  logic o_prev_sl, o_prev_cl;

  task automatic scen_begin();
    cyc = 0;
    o_first_sevt = -1; o_first_cevt = -1; o_cnt_sevt = 0; o_cnt_cevt = 0;
    o_cnt_ss = 0; o_cnt_clr = 0; o_first_clr = -1; o_last_clr = -1;
    o_lvl_s_rise = -1; o_lvl_c_rise = -1;
    o_prev_sl = start_level; o_prev_cl = clear_level;
  endtask

  task automatic step(input bit s, input bit c);
    btn_start_raw = s;
    btn_clear_raw = c;
    @(posedge clk);
    model_step(s, c);
    #1;
    check6("model", dut_out, m_out);
    if (start_evt) begin o_cnt_sevt++; if (o_first_sevt < 0) o_first_sevt = cyc; end
    if (clear_evt) begin o_cnt_cevt++; if (o_first_cevt < 0) o_first_cevt = cyc; end
    if (start_stop) o_cnt_ss++;
    if (clear) begin
      o_cnt_clr++; o_last_clr = cyc;
      if (o_first_clr < 0) o_first_clr = cyc;
    end
    if (start_level && !o_prev_sl && o_lvl_s_rise < 0) o_lvl_s_rise = cyc;
    if (clear_level && !o_prev_cl && o_lvl_c_rise < 0) o_lvl_c_rise = cyc;
    o_prev_sl = start_level; o_prev_cl = clear_level;
    cyc++;
  endtask

  task automatic run_rows(input bit s, input bit c, input int k);
    for (int i = 0; i < k; i++) step(s, c);
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    #1;
    check6("reset_async", dut_out, 6'b0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  typedef struct {
    bit         s;
    bit         c;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[22];

  initial begin
    bit rs, rc;
    // Clean start press held 10 cycles: level rises at row 5, falls at 15,
    // start_evt at 15, start_stop rows 16..18.
    for (int i = 0; i < 22; i++) begin
      tbl[i].s   = (i < 10);
      tbl[i].c   = 1'b0;
      tbl[i].exp = {(i >= 5 && i <= 14), (i == 15), (i >= 16 && i <= 18), 3'b000};
    end

    reset = 1'b0;
    btn_start_raw = 1'b0;
    btn_clear_raw = 1'b0;
    m_n = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check6("reset_state", dut_out, 6'b0);
    reset = 1'b1;

    // Table-driven clean start press.
    scen_begin();
    for (int i = 0; i < 22; i++) begin
      step(tbl[i].s, tbl[i].c);
      check6("tbl_start_press", dut_out, tbl[i].exp);
    end
    run_rows(0, 0, 10);

    // Bouncy clear then steady press.
    scen_begin();
    begin
      bit pat[6] = '{1, 0, 1, 1, 0, 1};
      for (int i = 0; i < 6; i++) step(0, pat[i]);
    end
    run_rows(0, 1, 10);
    run_rows(0, 0, 12);
    check_int("bounce_level_rise", o_lvl_c_rise, 10);
    check_int("bounce_clear_evt_cyc", o_first_cevt, 10);
    check_int("bounce_clear_evt_cnt", o_cnt_cevt, 1);
    check_int("bounce_clear_width", o_cnt_clr, P);
    run_rows(0, 0, 10);

    // Long start press converts to clear.
    scen_begin();
    run_rows(1, 0, 30);
    run_rows(0, 0, 16);
    check_int("long_level_rise", o_lvl_s_rise, 5);
    check_int("long_clear_evt_cyc", o_first_cevt, 25);
    check_int("long_clear_evt_cnt", o_cnt_cevt, 1);
    check_int("long_no_start_evt", o_cnt_sevt, 0);
    check_int("long_no_start_stop", o_cnt_ss, 0);
    run_rows(0, 0, 10);

    // Clear press accepted in the same cycle as a short start release.
    scen_begin();
    run_rows(1, 0, 10);
    run_rows(0, 1, 10);
    run_rows(0, 0, 16);
    check_int("simul_clear_evt_cyc", o_first_cevt, 15);
    check_int("simul_no_start_evt", o_cnt_sevt, 0);
    check_int("simul_no_start_stop", o_cnt_ss, 0);
    run_rows(0, 0, 10);

    // Clear event one cycle after a start event cancels the start stretcher.
    scen_begin();
    run_rows(1, 0, 10);
    step(0, 0);
    run_rows(0, 1, 10);
    run_rows(0, 0, 15);
    check_int("cancel_start_evt_cyc", o_first_sevt, 15);
    check_int("cancel_clear_evt_cyc", o_first_cevt, 16);
    check_int("cancel_start_stop_width", o_cnt_ss, 1);
    run_rows(0, 0, 10);

    // Two clear events two cycles apart: stretched clear has no gap.
    scen_begin();
    run_rows(1, 0, 22);
    run_rows(1, 1, 8);
    run_rows(0, 0, 16);
    check_int("extend_clear_evt_cnt", o_cnt_cevt, 2);
    check_int("extend_first_clear", o_first_clr, 26);
    check_int("extend_last_clear", o_last_clr, 30);
    check_int("extend_clear_width", o_cnt_clr, 5);
    check_int("extend_no_start_evt", o_cnt_sevt, 0);
    run_rows(0, 0, 10);

    // Reset mid-stretch with the start button held.
    scen_begin();
    run_rows(1, 0, 10);
    run_rows(0, 0, 6);
    step(1, 0);
    check_int("rst_pre_start_evt", o_first_sevt, 15);
    check_int("rst_pre_start_stop", int'(start_stop), 1);
    reset_pulse();
    scen_begin();
    run_rows(1, 0, 12);
    run_rows(0, 0, 10);
    check_int("rst_level_return", o_lvl_s_rise, 5);
    check_int("rst_start_evt_cyc", o_first_sevt, 17);
    check_int("rst_start_evt_cnt", o_cnt_sevt, 1);
    check_int("rst_no_clear_evt", o_cnt_cevt, 0);
    run_rows(0, 0, 10);

    // Randomized buttons with occasional resets, checked against the model.
    rs = 0; rc = 0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 9) == 0) rs = !rs;
      if ($urandom_range(0, 11) == 0) rc = !rc;
      if ($urandom_range(0, 599) == 0) reset_pulse();
      step(rs, rc);
    end
    run_rows(0, 0, 30);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
